// File: rtl/ib_prefetch.sv
// Instruction-byte prefetch buffer: fetches aligned longwords into a circular
// byte queue and presents the next two bytes, with their PC, to the decoder.
module ib_prefetch #(
  parameter int QBYTES = 8,
  parameter int VAW    = 32
) (
  input  logic           mclk_l,
  input  logic           reset_l,
  input  logic           flush_h,
  input  logic [VAW-1:0] flush_pc_h,
  input  logic [1:0]     consume_h,
  output logic [15:0]    xbuf_h,
  output logic [1:0]     ib_vld_h,
  output logic [VAW-1:0] pc_h,
  output logic           ib_err_h,
  output logic           mem_req_h,
  output logic [VAW-1:0] mem_addr_h,
  input  logic           mem_ack_h,
  input  logic [31:0]    mem_data_h,
  input  logic           mem_err_h
);

  localparam int HW = $clog2(QBYTES);
  localparam int CW = HW + 1;

  logic [HW-1:0]  head_q, head_d;
  logic [CW-1:0]  count_q, count_d;
  logic [VAW-1:0] pc_q, pc_d;
  logic [VAW-1:0] fpc_q, fpc_d;
  logic [1:0]     skip_q, skip_d;
  logic           err_q, err_d;
  logic           req_q, req_d;
  // Fetching is idle out of reset until the first flush supplies a PC.
  logic           run_q, run_d;

  logic [7:0]     qmem [QBYTES];

  logic [1:0]     eff;
  logic [2:0]     fill;
  logic           fill_en;
  logic [CW-1:0]  free;
  logic [CW-1:0]  need;
  logic [HW-1:0]  tail;
  logic [HW-1:0]  head_nx;
  logic [HW-1:0]  widx [4];

  always_comb begin
    ib_vld_h = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
    eff      = (consume_h > ib_vld_h) ? ib_vld_h : consume_h;
    free     = CW'(QBYTES) - count_q;
    need     = CW'(3'd4 - {1'b0, skip_q});
    tail     = head_q + count_q[HW-1:0];
    head_nx  = head_q + HW'(1);
    fill_en  = !flush_h && req_q && mem_ack_h && !mem_err_h;
    fill     = fill_en ? (3'd4 - {1'b0, skip_q}) : 3'd0;
    for (int i = 0; i < 4; i++) begin
      widx[i] = tail + HW'(i) - HW'(skip_q);
    end
  end

  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    pc_d    = pc_q;
    fpc_d   = fpc_q;
    skip_d  = skip_q;
    err_d   = err_q;
    req_d   = req_q;
    run_d   = run_q;
    if (flush_h) begin
      count_d = '0;
      err_d   = 1'b0;
      pc_d    = flush_pc_h;
      fpc_d   = {flush_pc_h[VAW-1:2], 2'b00};
      skip_d  = flush_pc_h[1:0];
      req_d   = 1'b0;
      run_d   = 1'b1;
    end else begin
      head_d  = head_q + HW'(eff);
      pc_d    = pc_q + VAW'(eff);
      count_d = count_q - CW'(eff) + CW'(fill);
      if (req_q && mem_ack_h) begin
        req_d = 1'b0;
        if (mem_err_h) begin
          err_d = 1'b1;
        end else begin
          skip_d = 2'd0;
          fpc_d  = fpc_q + VAW'(4);
        end
      end else if (!req_q && run_q && !err_q && (free >= need)) begin
        // Space is judged before this cycle's consume, so a request never
        // depends on the decoder's same-cycle handshake.
        req_d = 1'b1;
      end
    end
  end

  always_ff @(posedge mclk_l or negedge reset_l) begin
    if (!reset_l) begin
      head_q  <= '0;
      count_q <= '0;
      pc_q    <= '0;
      fpc_q   <= '0;
      skip_q  <= 2'd0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      fpc_q   <= fpc_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
      req_q   <= req_d;
      run_q   <= run_d;
    end
  end

  // Byte storage needs no reset: lanes beyond the valid count are masked.
  always_ff @(posedge mclk_l) begin
    if (fill_en) begin
      for (int i = 0; i < 4; i++) begin
        if (2'(i) >= skip_q) begin
          qmem[widx[i]] <= mem_data_h[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    xbuf_h[7:0]  = (ib_vld_h != 2'd0) ? qmem[head_q]  : 8'h00;
    xbuf_h[15:8] = (ib_vld_h == 2'd2) ? qmem[head_nx] : 8'h00;
    pc_h         = pc_q;
    mem_req_h    = req_q;
    mem_addr_h   = fpc_q;
    ib_err_h     = err_q && (count_q == '0);
  end

endmodule
